pipe_hazard_ctrl: RTL

Pipeline sequencer for the 5-stage RV32I core. It drives the `stg_ena`/`stg_x` pair of every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It detects three conditions and acts on them: load-use hazards, taken branches, and data-memory wait states. It also provides a halt/resume mechanism and a watchdog on memory wait length.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/load_use_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_pkg;
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } pipe_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose rd feeds a source of the ID instruction.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rd_memory,
    input  logic       ex_save_to_reg,
    output logic       lu
);
    logic src_match;

    assign src_match = (id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd));

    assign lu = ex_rd_memory && ex_save_to_reg && (ex_rd != REG_ZERO) && src_match;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: stalls, flushes, memory waits, halt/resume and a memory-wait watchdog.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       stg_clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rd_memory,
    input  logic       ex_save_to_reg,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    input  logic       halt_req,
    input  logic       resume,
    output logic       pc_ena,
    output logic       pc_sel_branch,
    output logic       stg_ena_ifid,
    output logic       stg_ena_idex,
    output logic       stg_ena_exmem,
    output logic       stg_ena_memwb,
    output logic       stg_x_ifid,
    output logic       stg_x_idex,
    output logic       stg_x_exmem,
    output logic       stg_x_memwb,
    output logic [1:0] state,
    output logic       mem_timeout_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             lu;

    load_use_detect u_lu (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_rd          (ex_rd),
        .ex_rd_memory   (ex_rd_memory),
        .ex_save_to_reg (ex_save_to_reg),
        .lu             (lu)
    );

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Watchdog: counts consecutive busy cycles, saturating; the flag is sticky and never aborts the wait.
    always_comb begin
        wait_cnt_d = '0;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        err_d = err_q || (wait_cnt_d == CNT_MAX);
    end

    always_comb begin
        state_d       = state_q;
        pc_ena        = 1'b0;
        pc_sel_branch = 1'b0;
        stg_ena_ifid  = 1'b0;
        stg_ena_idex  = 1'b0;
        stg_ena_exmem = 1'b0;
        stg_ena_memwb = 1'b0;
        stg_x_ifid    = 1'b1;
        stg_x_idex    = 1'b1;
        stg_x_exmem   = 1'b1;
        stg_x_memwb   = 1'b1;
        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN, MEM_WAIT: begin
                // MEM_WAIT shares RUN's priority chain once memory is ready.
                if (mem_busy) begin
                    stg_x_ifid  = 1'b0;
                    stg_x_idex  = 1'b0;
                    stg_x_exmem = 1'b0;
                    state_d     = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    pc_ena        = 1'b1;
                    pc_sel_branch = 1'b1;
                    stg_ena_ifid  = 1'b1;
                    stg_ena_idex  = 1'b1;
                    stg_ena_exmem = 1'b1;
                    stg_ena_memwb = 1'b1;
                    stg_x_exmem   = 1'b0;
                    stg_x_memwb   = 1'b0;
                    state_d       = RUN;
                end else if (lu) begin
                    stg_ena_idex  = 1'b1;
                    stg_ena_exmem = 1'b1;
                    stg_ena_memwb = 1'b1;
                    stg_x_ifid    = 1'b0;
                    stg_x_exmem   = 1'b0;
                    stg_x_memwb   = 1'b0;
                    state_d       = RUN;
                end else begin
                    pc_ena        = 1'b1;
                    stg_ena_ifid  = 1'b1;
                    stg_ena_idex  = 1'b1;
                    stg_ena_exmem = 1'b1;
                    stg_ena_memwb = 1'b1;
                    stg_x_ifid    = 1'b0;
                    stg_x_idex    = 1'b0;
                    stg_x_exmem   = 1'b0;
                    stg_x_memwb   = 1'b0;
                    state_d       = halt_req ? HALT : RUN;
                end
            end
            HALT: begin
                stg_ena_idex = 1'b1;
                stg_x_ifid   = 1'b0;
                stg_x_exmem  = 1'b0;
                if (!mem_busy) begin
                    stg_ena_exmem = 1'b1;
                    stg_ena_memwb = 1'b1;
                    stg_x_memwb   = 1'b0;
                    if (resume) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign state           = state_q;
    assign mem_timeout_err = err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (((state_q == RUN) && lu) || (state_q == MEM_WAIT)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pc_sel_branch) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule
